bus8_arbiter: RTL and testbench
===============================

BUS8_ARBITER -- requirements
Module: bus8_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 4, giving the max consecutive grant cycles per owner while the other side waits (legal range 2..16).
REQ-002 The block SHALL have port clock, input, 1, single rising-edge clock for all state.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req_a, input, 1, requester A wants the 8-bit bus.
REQ-005 The block SHALL have port data_a, input, 8, requester A payload.
REQ-006 The block SHALL have port req_b, input, 1, requester B wants the 8-bit bus.
REQ-007 The block SHALL have port data_b, input, 8, requester B payload.
REQ-008 The block SHALL have port gnt_a, output, 1, A owns the bus this cycle.
REQ-009 The block SHALL have port gnt_b, output, 1, B owns the bus this cycle.
REQ-010 The block SHALL have port sel, output, 1, mux select (1 = A, 0 = B).
REQ-011 The block SHALL have port data_out, output, 8, registered bus value.
REQ-012 The block SHALL have port out_valid, output, 1, data_out holds a transferred beat.

Function
REQ-013 The FSM SHALL have states IDLE, OWN_A, OWN_B, with gnt_a = (state==OWN_A), gnt_b = (state==OWN_B), and sel = 1 in OWN_A, else 0.
REQ-014 IDLE: req_a only -> OWN_A; req_b only -> OWN_B; both -> the side not equal to last_owner; neither -> IDLE.
REQ-015 OWN_X with req_X low: go to OWN_other if req_other high, else IDLE; no beat transfers that cycle.
REQ-016 OWN_X with req_X high and req_other low: stay OWN_X; burst_cnt saturates at MAX_BURST-1.
REQ-017 OWN_X with req_X high, req_other high and burst_cnt == MAX_BURST-1: go to OWN_other; the current beat still transfers.
REQ-018 OWN_X in all other cases: stay OWN_X and increment burst_cnt.
REQ-019 burst_cnt SHALL clear to 0 on every state change and in IDLE.
REQ-020 last_owner SHALL update to X on every entry to OWN_X.
REQ-021 Beat rule: in a cycle with gnt_X high and req_X high, the next edge SHALL load data_out with data_X and set out_valid = 1; otherwise out_valid = 0 and data_out holds its value. Latency is 1 clock.
REQ-022 gnt_a and gnt_b SHALL never be high together.
REQ-023 A waiting requester SHALL be granted within MAX_BURST+1 cycles of asserting req.

Reset
REQ-024 While reset_n is low: state = IDLE, gnt_a = gnt_b = 0, sel = 0, data_out = 8'h00, out_valid = 0, burst_cnt = 0, last_owner = B (so A wins the first tie).
REQ-025 Reset asserted mid-burst SHALL clear all outputs immediately, without waiting for clock; the first arbitration SHALL occur on the first rising edge after reset_n rises.

Structure
REQ-026 A shared package SHALL hold the state encoding constants (IDLE=2'b00, OWN_A=2'b01, OWN_B=2'b10) and the MAX_BURST default.
REQ-027 The 8-bit select path SHALL be one sub-module, mux8_2to1 (inA, inB, ctrl, out), with ctrl driven by sel; arbitration, counter and output register stay in bus8_arbiter.

Verification
REQ-028 Reset then req_a=1, data_a=8'h5A, req_b=0 -> gnt_a=1 after edge 1; data_out=8'h5A, out_valid=1 after edge 2.
REQ-029 Both requests rise together from IDLE after reset -> OWN_A first; A keeps the bus for exactly 4 beats (MAX_BURST=4), then gnt_b=1 on the next cycle.
REQ-030 B alone for 10 cycles -> gnt_b stays high throughout, with no forced handover; burst_cnt saturates at 3.
REQ-031 A drops req_a while B requests -> next cycle gnt_b=1, gnt_a=0; the cycle with req_a low produces out_valid=0.
REQ-032 reset_n pulled low mid-burst in OWN_B with data_out=8'hC3 -> asynchronously gnt_b=0, data_out=8'h00, out_valid=0; after release with both requesting -> A granted.
REQ-033 Random req_a/req_b for 1000 cycles -> gnt_a and gnt_b never both high, and no waiting requester is starved beyond 5 cycles.

Source files
------------

// File: rtl/bus8_arbiter_pkg.sv
// Shared definitions for the two-requester 8-bit bus arbiter: state encoding,
// default burst limit and the saturating burst-counter helper.
package bus8_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_e;

  localparam int unsigned MAX_BURST_DEFAULT = 4;
  localparam int unsigned CNT_W             = 4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    if (v >= lim) begin
      return lim;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/bus8_arbiter_mux.sv
// 8-bit two-input select path feeding the arbiter's output register.
module mux8_2to1 (
  input  logic [7:0] inA,
  input  logic [7:0] inB,
  input  logic       ctrl,
  output logic [7:0] out
);

  assign out = ctrl ? inA : inB;

endmodule

// File: rtl/bus8_arbiter.sv
// Two-requester 8-bit bus arbiter: fair tie-break on last owner, burst limit
// while the other side waits, registered one-beat-latency output.
module bus8_arbiter
  import bus8_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req_a,
  input  logic [7:0] data_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       sel,
  output logic [7:0] data_out,
  output logic       out_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_is_a_q, last_is_a_d;
  logic             gnt_a_q, gnt_b_q, sel_q;
  logic [7:0]       data_out_q;
  logic             out_valid_q;
  logic             own_req_s, oth_req_s, beat_s;
  logic [7:0]       mux_out_s;

  mux8_2to1 u_mux (
    .inA  (data_a),
    .inB  (data_b),
    .ctrl (sel_q),
    .out  (mux_out_s)
  );

  assign own_req_s = (state_q == OWN_A) ? req_a : req_b;
  assign oth_req_s = (state_q == OWN_A) ? req_b : req_a;
  assign beat_s    = ((state_q == OWN_A) && req_a) || ((state_q == OWN_B) && req_b);

  // Next owner, burst count and tie-break memory.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_is_a_d = last_is_a_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_a && req_b) begin
          state_d = last_is_a_q ? OWN_B : OWN_A;
        end else if (req_a) begin
          state_d = OWN_A;
        end else if (req_b) begin
          state_d = OWN_B;
        end else begin
          state_d = IDLE;
        end
      end
      OWN_A, OWN_B: begin
        if (!own_req_s) begin
          cnt_d = '0;
          if (oth_req_s) begin
            state_d = (state_q == OWN_A) ? OWN_B : OWN_A;
          end else begin
            state_d = IDLE;
          end
        end else if (!oth_req_s) begin
          cnt_d = sat_inc(cnt_q, CNT_MAX);
        end else if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = (state_q == OWN_A) ? OWN_B : OWN_A;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if ((state_d == OWN_A) && (state_q != OWN_A)) begin
      last_is_a_d = 1'b1;
    end else if ((state_d == OWN_B) && (state_q != OWN_B)) begin
      last_is_a_d = 1'b0;
    end else begin
      last_is_a_d = last_is_a_q;
    end
  end

  // Arbiter state with grants/select registered from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_is_a_q <= 1'b0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      sel_q       <= 1'b0;
      data_out_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_is_a_q <= last_is_a_d;
      gnt_a_q     <= (state_d == OWN_A);
      gnt_b_q     <= (state_d == OWN_B);
      sel_q       <= (state_d == OWN_A);
      out_valid_q <= beat_s;
      if (beat_s) begin
        data_out_q <= mux_out_s;
      end else begin
        data_out_q <= data_out_q;
      end
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign sel       = sel_q;
  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bus8_arbiter.sv
// Self-checking bench for bus8_arbiter: directed vector table, hand sequences
// for saturation and async reset, and a randomized run against an ownership model.
module tb_bus8_arbiter;

  localparam int MAXB = 4;

  logic       clock, reset_n;
  logic       req_a, req_b;
  logic [7:0] data_a, data_b;
  logic       gnt_a, gnt_b, sel, out_valid;
  logic [7:0] data_out;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the bus and for how many cycles in a row.
  int         m_owner;
  int         m_held;
  int         m_last;
  logic [7:0] m_dout;
  logic       m_valid;
  int         wait_a, wait_b;

  typedef struct {
    bit         rst;
    bit         ra;
    logic [7:0] da;
    bit         rb;
    logic [7:0] db;
    bit         ega;
    bit         egb;
    bit         ev;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl[11];

  bus8_arbiter #(.MAX_BURST(MAXB)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_a     (req_a),
    .data_a    (data_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .sel       (sel),
    .data_out  (data_out),
    .out_valid (out_valid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_held  = 0;
    m_last  = 2;
    m_dout  = 8'h00;
    m_valid = 1'b0;
    wait_a  = 0;
    wait_b  = 0;
  endtask

  // Advance the model by one clock using the inputs presented before the edge.
  task automatic model_step();
    int  nxt;
    bit  own_r, oth_r;
    if (m_owner == 1 && req_a) begin
      m_dout = data_a; m_valid = 1'b1;
    end else if (m_owner == 2 && req_b) begin
      m_dout = data_b; m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (m_owner == 0) begin
      if (req_a && req_b) nxt = (m_last == 1) ? 2 : 1;
      else if (req_a)     nxt = 1;
      else if (req_b)     nxt = 2;
      else                nxt = 0;
    end else begin
      own_r = (m_owner == 1) ? req_a : req_b;
      oth_r = (m_owner == 1) ? req_b : req_a;
      if (!own_r)                     nxt = oth_r ? 3 - m_owner : 0;
      else if (oth_r && m_held >= MAXB) nxt = 3 - m_owner;
      else                            nxt = m_owner;
    end
    if (nxt != m_owner) begin
      m_held = (nxt != 0) ? 1 : 0;
      if (nxt != 0) m_last = nxt;
    end else if (nxt != 0) begin
      m_held++;
    end
    m_owner = nxt;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; data_a = 8'h00; data_b = 8'h00;
    @(negedge clock);
    chk("reset_state", {20'h0, gnt_a, gnt_b, sel, out_valid, data_out}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    reset_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; data_a = 8'h00; data_b = 8'h00;
    model_reset();

    //          rst   ra    da     rb    db     ga    gb    v     d
    tbl[0]  = '{1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5A};
    tbl[2]  = '{1'b1, 1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1, 1'b0, 1'b1, 8'hA1};
    tbl[4]  = '{1'b0, 1'b1, 8'hA2, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b1, 8'hA2};
    tbl[5]  = '{1'b0, 1'b1, 8'hA3, 1'b1, 8'hB3, 1'b1, 1'b0, 1'b1, 8'hA3};
    tbl[6]  = '{1'b0, 1'b1, 8'hA4, 1'b1, 8'hB4, 1'b0, 1'b1, 1'b1, 8'hA4};
    tbl[7]  = '{1'b0, 1'b1, 8'hA7, 1'b1, 8'hB5, 1'b0, 1'b1, 1'b1, 8'hB5};
    tbl[8]  = '{1'b0, 1'b1, 8'hA8, 1'b0, 8'hEE, 1'b1, 1'b0, 1'b0, 8'hB5};
    tbl[9]  = '{1'b0, 1'b0, 8'hA9, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 8'hB5};
    tbl[10] = '{1'b0, 1'b0, 8'hAA, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3};

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst) do_reset();
      req_a = tbl[i].ra; data_a = tbl[i].da;
      req_b = tbl[i].rb; data_b = tbl[i].db;
      @(posedge clock);
      #1;
      chk($sformatf("row%0d", i),
          {20'h0, gnt_a, gnt_b, sel, out_valid, data_out},
          {20'h0, tbl[i].ega, tbl[i].egb, tbl[i].ega, tbl[i].ev, tbl[i].ed});
    end

    // Mid-burst in OWN_B holding 8'hC3: reset must clear outputs without a clock.
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst", {20'h0, gnt_a, gnt_b, sel, out_valid, data_out}, 32'h0);
    req_a = 1'b1; req_b = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("post_rst_tie", {30'h0, gnt_a, gnt_b}, 32'h2);

    // B alone for 10 cycles, then A joins: saturated count forces immediate handover.
    do_reset();
    req_a = 1'b0; req_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_b = 8'(i);
      @(posedge clock);
      #1;
      chk($sformatf("b_alone%0d", i), {30'h0, gnt_a, gnt_b}, 32'h1);
    end
    req_a = 1'b1; data_b = 8'h99;
    @(posedge clock);
    #1;
    chk("sat_handover", {30'h0, gnt_a, gnt_b}, 32'h2);
    chk("sat_last_beat", {23'h0, out_valid, data_out}, {23'h0, 1'b1, 8'h99});

    // Random traffic against the ownership model.
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      req_a  = ($urandom_range(0, 99) < 70);
      req_b  = ($urandom_range(0, 99) < 70);
      data_a = 8'($urandom);
      data_b = 8'($urandom);
      @(posedge clock);
      model_step();
      #1;
      chk($sformatf("rand%0d", c),
          {20'h0, gnt_a, gnt_b, sel, out_valid, data_out},
          {20'h0, (m_owner == 1), (m_owner == 2), (m_owner == 1), m_valid, m_dout});
      chk("excl", {31'h0, gnt_a & gnt_b}, 32'h0);
      wait_a = (req_a && !gnt_a) ? wait_a + 1 : 0;
      wait_b = (req_b && !gnt_b) ? wait_b + 1 : 0;
      chk("starve", {31'h0, (wait_a <= MAXB + 1) && (wait_b <= MAXB + 1)}, 32'h1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
